// File: rtl/conv1_mac_engine.sv
// conv1_mac_engine
//   First-layer convolution MAC. It runs in lockstep with the conv1 weight
//   streamer and takes one 5x5 tap per clock for three output channels.
//   Each channel accumulates TAPS signed Q8.8 products and adds its bias.
//   The sum then gets optional ReLU, a truncating shift back to Q8.8 and
//   16-bit signed saturation. One 3-channel result is emitted per window.
//
// Ports
//   clk_i           rising-edge clock
//   reset_i         synchronous active-high reset
//   start_i         run enable, shared with the weight streamer
//   pixel_in_i      Q8.8 pixel aligned to the current tap weight
//   weight_conv1_i  [3:1] Q8.8 tap weight per channel
//   bias_conv1_i    [3:1] Q8.8 bias per channel, sampled when a result is formed
//   conv_out_o      [3:1] Q8.8 window result; holds its value between pulses
//   out_valid_o     one-cycle pulse, conv_out_o is valid while it is high
//   out_index_o     window number since the last start rise, from 0
module conv1_mac_engine #(
   parameter int TAPS      = 25,
   parameter int FRAC_BITS = 8,
   parameter int RELU      = 1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic signed [15:0]     pixel_in_i,
   input  logic signed [3:1][15:0] weight_conv1_i,
   input  logic signed [3:1][15:0] bias_conv1_i,
   output logic signed [3:1][15:0] conv_out_o,
   output logic                   out_valid_o,
   output logic [15:0]            out_index_o
);

   localparam int CNT_W = $clog2(TAPS + 1);
   localparam int ACC_W = 37;
   localparam int SUM_W = 38;
   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(32767);
   localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-32768);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRIME,
      S_RUN
   } state_t;

   state_t           state_q, state_d;
   logic             tap_en;     // sample a tap on this edge
   logic             prime;      // leading zero tap is being discarded
   logic             clr_idx;    // IDLE -> PRIME, restart window numbering
   logic [CNT_W-1:0] tap_cnt_q;

   logic             p1_vld_q, p1_first_q, p1_last_q;
   logic             fin_vld_q;
   logic             out_valid_q;
   logic [15:0]      win_cnt_q, out_index_q;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      tap_en  = 1'b0;
      prime   = 1'b0;
      clr_idx = 1'b0;
      if (!start_i) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_PRIME;
               clr_idx = 1'b1;
            end
            S_PRIME: begin
               state_d = S_RUN;
               prime   = 1'b1;
            end
            S_RUN:   tap_en = 1'b1;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Tap counter runs 1..TAPS and wraps straight back to 1, so consecutive
   // windows share no idle cycle.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tap_cnt_q <= '0;
      end else if (prime) begin
         tap_cnt_q <= CNT_W'(1);
      end else if (tap_en) begin
         tap_cnt_q <= (tap_cnt_q == CNT_W'(TAPS)) ? CNT_W'(1) : tap_cnt_q + CNT_W'(1);
      end
   end

   // ---------------- shared pipeline flags ----------------
   // P2 and P3 are not gated by start: a window whose last tap was already
   // sampled still drains after start falls. A partial window is never
   // forwarded. The next window's first tap reloads the accumulator anyway.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         p1_vld_q    <= 1'b0;
         p1_first_q  <= 1'b0;
         p1_last_q   <= 1'b0;
         fin_vld_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         p1_vld_q    <= tap_en;
         p1_first_q  <= tap_en && (tap_cnt_q == CNT_W'(1));
         p1_last_q   <= tap_en && (tap_cnt_q == CNT_W'(TAPS));
         fin_vld_q   <= p1_vld_q && p1_last_q;
         out_valid_q <= fin_vld_q;
      end
   end

   // out_index_o carries the number of the window being emitted. A start
   // rise resets numbering. A result that drains on that same edge keeps
   // its old number.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         win_cnt_q   <= '0;
         out_index_q <= '0;
      end else begin
         if (fin_vld_q) begin
            out_index_q <= win_cnt_q;
            win_cnt_q   <= win_cnt_q + 16'd1;
         end
         if (clr_idx) begin
            win_cnt_q <= '0;
            if (!fin_vld_q) out_index_q <= '0;
         end
      end
   end

   // Bias alignment, optional ReLU, truncating shift to Q8.8 and saturation.
   function automatic logic [15:0] post_proc(input logic signed [ACC_W-1:0] fin,
                                             input logic signed [15:0]      b);
      logic signed [SUM_W-1:0] s;
      logic signed [SUM_W-1:0] sh;
      s = SUM_W'(fin) + (SUM_W'(b) <<< FRAC_BITS);
      if (RELU != 0 && s[SUM_W-1]) s = '0;
      sh = s >>> FRAC_BITS;
      if (sh > SAT_MAX)      post_proc = 16'h7FFF;
      else if (sh < SAT_MIN) post_proc = 16'h8000;
      else                   post_proc = sh[15:0];
   endfunction

   // ---------------- per-channel datapath ----------------
   for (genvar c = 1; c <= 3; c++) begin : g_ch
      logic signed [31:0]      prod_q;
      logic signed [ACC_W-1:0] acc_q, fin_q;
      logic signed [ACC_W-1:0] prod_x, acc_base, acc_d;
      logic signed [15:0]      w_s, b_s;
      logic [15:0]             out_q;

      assign w_s      = $signed(weight_conv1_i[c]);
      assign b_s      = $signed(bias_conv1_i[c]);
      assign prod_x   = ACC_W'(prod_q);
      // First tap of a window loads the product instead of adding it.
      assign acc_base = p1_first_q ? '0 : acc_q;
      assign acc_d    = acc_base + prod_x;

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            prod_q <= '0;
            acc_q  <= '0;
            fin_q  <= '0;
            out_q  <= '0;
         end else begin
            if (tap_en) prod_q <= pixel_in_i * w_s;
            if (p1_vld_q) begin
               acc_q <= acc_d;
               if (p1_last_q) fin_q <= acc_d;
            end
            if (fin_vld_q) out_q <= post_proc(fin_q, b_s);
         end
      end

      assign conv_out_o[c] = out_q;
   end

   assign out_valid_o = out_valid_q;
   assign out_index_o = out_index_q;

endmodule

// File: tb/tb_conv1_mac_engine.sv
module tb_conv1_mac_engine;

   logic                    clk = 1'b0;
   logic                    reset, start;
   logic signed [15:0]      pixel;
   logic signed [3:1][15:0] weight, bias;
   logic [3:1][15:0]        cout1, cout0;
   logic                    ov1_s, ov0_s;
   logic [15:0]             idx1, idx0;

   int total = 0;
   int bad   = 0;

   // Stimulus pattern for up to four windows and per-edge observations.
   logic signed [15:0] pat_px [0:99];
   logic signed [15:0] pat_w  [1:3][0:99];
   logic               ov1 [0:127];
   logic               ov0 [0:127];
   logic [3:1][15:0]   oc1 [0:127];
   logic [3:1][15:0]   oc0 [0:127];
   logic [15:0]        oi1 [0:127];
   logic [15:0]        oi0 [0:127];

   always #5 clk = ~clk;

   conv1_mac_engine #(.TAPS(25), .FRAC_BITS(8), .RELU(1)) dut1 (
      .clk_i(clk), .reset_i(reset), .start_i(start), .pixel_in_i(pixel),
      .weight_conv1_i(weight), .bias_conv1_i(bias), .conv_out_o(cout1),
      .out_valid_o(ov1_s), .out_index_o(idx1));

   conv1_mac_engine #(.TAPS(25), .FRAC_BITS(8), .RELU(0)) dut0 (
      .clk_i(clk), .reset_i(reset), .start_i(start), .pixel_in_i(pixel),
      .weight_conv1_i(weight), .bias_conv1_i(bias), .conv_out_o(cout0),
      .out_valid_o(ov0_s), .out_index_o(idx0));

   // Reference: exact integer dot product + bias, ReLU, floor shift, clamp.
   function automatic logic [15:0] model(input int win, input int ch, input bit relu);
      longint s;
      s = 0;
      for (int t = 0; t < 25; t++)
         s += longint'(pat_px[win*25+t]) * longint'(pat_w[ch][win*25+t]);
      s += longint'($signed(bias[ch])) * 256;
      if (relu && s < 0) s = 0;
      s = s >>> 8;
      if (s > 32767)  return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return s[15:0];
   endfunction

   // Window emitted after edge e (relative to the start rise), or -1.
   // Window w's last tap lands on edge 26+25w and its result two edges later.
   function automatic int exp_win(input int e, input int nstart, input int rst_e);
      for (int w = 0; w < 4; w++)
         if (e == 28 + 25*w && 26 + 25*w < nstart && (rst_e < 0 || 28 + 25*w < rst_e))
            return w;
      return -1;
   endfunction

   // Drives one run: start high for edges < nstart (and < rst_e), zero tap on
   // edges 0 and 1, pattern taps from edge 2. Records outputs 1ns after each edge.
   task automatic stream(input int nstart, input int ntot, input int rst_e);
      for (int e = 0; e < ntot; e++) begin
         @(negedge clk);
         reset = (e == rst_e);
         start = (e < nstart) && (rst_e < 0 || e < rst_e);
         if (start && e >= 2) begin
            pixel = pat_px[e-2];
            for (int c = 1; c <= 3; c++) weight[c] = pat_w[c][e-2];
         end else begin
            pixel  = '0;
            weight = '0;
         end
         @(posedge clk);
         #1;
         ov1[e] = ov1_s; ov0[e] = ov0_s;
         oc1[e] = cout1; oc0[e] = cout0;
         oi1[e] = idx1;  oi0[e] = idx0;
      end
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
   endtask

   task automatic fill_const(input logic [15:0] px, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
      for (int i = 0; i < 100; i++) begin
         pat_px[i] = px; pat_w[1][i] = w1; pat_w[2][i] = w2; pat_w[3][i] = w3;
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 100; i++) begin
         pat_px[i] = 16'(int'($urandom_range(2047)) - 1024);
         for (int c = 1; c <= 3; c++) pat_w[c][i] = 16'(int'($urandom_range(1023)) - 512);
      end
      for (int c = 1; c <= 3; c++) bias[c] = 16'(int'($urandom_range(4095)) - 2048);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; pixel = '0; weight = '0; bias = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (ov1_s !== 1'b0 || ov0_s !== 1'b0 || cout1 !== '0 || cout0 !== '0 ||
          idx1 !== 16'd0 || idx0 !== 16'd0) begin
         bad++;
         $display("FAIL reset_state got v=%b/%b out=%h/%h idx=%0d/%0d want all zero",
                  ov1_s, ov0_s, cout1, cout0, idx1, idx0);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_ones();
      int w;
      fill_const(16'h0100, 16'h0100, 16'h0100, 16'h0100);
      bias = '0;
      stream(27, 32, -1);
      for (int e = 0; e < 32; e++) begin
         w = exp_win(e, 27, -1);
         total++;
         if (ov1[e] !== (w >= 0) || ov0[e] !== (w >= 0)) begin
            bad++;
            $display("FAIL ones_valid e%0d got %b/%b want %b", e, ov1[e], ov0[e], w >= 0);
         end
      end
      for (int c = 1; c <= 3; c++) begin
         total++;
         if (oc1[28][c] !== 16'h1900 || oc0[28][c] !== 16'h1900) begin
            bad++;
            $display("FAIL ones_out ch%0d got %h/%h want 1900", c, oc1[28][c], oc0[28][c]);
         end
      end
      total++;
      if (oi1[28] !== 16'd0) begin
         bad++; $display("FAIL ones_index got %0d want 0", oi1[28]);
      end
      total++;
      if (oc1[31] !== {3{16'h1900}}) begin
         bad++; $display("FAIL ones_hold got %h want 190019001900", oc1[31]);
      end
   endtask

   task automatic test_bias_relu();
      fill_const(16'h0100, 16'h0100, 16'hFF00, 16'h0080);
      bias[1] = 16'h0100; bias[2] = 16'h0000; bias[3] = 16'hFF00;
      stream(27, 30, -1);
      total++;
      if (ov1[28] !== 1'b1 || oc1[28] !== {16'h0B80, 16'h0000, 16'h1A00}) begin
         bad++;
         $display("FAIL bias_relu1 got v=%b %h want 1 0b8000001a00", ov1[28], oc1[28]);
      end
      total++;
      if (ov0[28] !== 1'b1 || oc0[28] !== {16'h0B80, 16'hE700, 16'h1A00}) begin
         bad++;
         $display("FAIL bias_relu0 got v=%b %h want 1 0b80e7001a00", ov0[28], oc0[28]);
      end
   endtask

   task automatic test_saturation();
      fill_const(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      bias = '0;
      stream(27, 30, -1);
      total++;
      if (oc1[28] !== {3{16'h7FFF}} || oc0[28] !== {3{16'h7FFF}}) begin
         bad++; $display("FAIL sat_pos got %h/%h want 7fff x3", oc1[28], oc0[28]);
      end
      fill_const(16'h7FFF, 16'h8000, 16'h8000, 16'h8000);
      stream(27, 30, -1);
      total++;
      if (oc0[28] !== {3{16'h8000}} || oc1[28] !== '0) begin
         bad++; $display("FAIL sat_neg got relu0=%h relu1=%h want 8000 x3 / 0", oc0[28], oc1[28]);
      end
   endtask

   task automatic test_back_to_back();
      int w;
      fill_rand();
      stream(77, 82, -1);
      for (int e = 0; e < 82; e++) begin
         w = exp_win(e, 77, -1);
         total++;
         if (ov1[e] !== (w >= 0) || ov0[e] !== (w >= 0)) begin
            bad++;
            $display("FAIL b2b_valid e%0d got %b/%b want %b", e, ov1[e], ov0[e], w >= 0);
         end
         if (w >= 0) begin
            for (int c = 1; c <= 3; c++) begin
               total++;
               if (oc1[e][c] !== model(w, c, 1) || oc0[e][c] !== model(w, c, 0)) begin
                  bad++;
                  $display("FAIL b2b_out w%0d ch%0d got %h/%h want %h/%h", w, c,
                           oc1[e][c], oc0[e][c], model(w, c, 1), model(w, c, 0));
               end
            end
            total++;
            if (oi1[e] !== 16'(w) || oi0[e] !== 16'(w)) begin
               bad++; $display("FAIL b2b_index got %0d/%0d want %0d", oi1[e], oi0[e], w);
            end
         end
      end
   endtask

   task automatic test_abort();
      fill_rand();
      stream(14, 40, -1);
      for (int e = 0; e < 40; e++) begin
         total++;
         if (ov1[e] !== 1'b0 || ov0[e] !== 1'b0) begin
            bad++; $display("FAIL abort_valid e%0d got %b/%b want 0", e, ov1[e], ov0[e]);
         end
      end
      fill_const(16'h0100, 16'h0100, 16'h0100, 16'h0100);
      bias = '0;
      stream(27, 30, -1);
      total++;
      if (ov1[28] !== 1'b1 || oc1[28] !== {3{16'h1900}} || oi1[28] !== 16'd0) begin
         bad++;
         $display("FAIL abort_restart got v=%b %h idx=%0d want 1 1900 x3 idx=0",
                  ov1[28], oc1[28], oi1[28]);
      end
   endtask

   task automatic test_reset_mid();
      int w;
      fill_rand();
      stream(90, 90, 71);
      total++;
      if (oi1[53] !== 16'd1 || ov1[53] !== 1'b1) begin
         bad++; $display("FAIL rstmid_pre got v=%b idx=%0d want 1 idx=1", ov1[53], oi1[53]);
      end
      total++;
      if (oc1[71] !== '0 || oc0[71] !== '0 || oi1[71] !== 16'd0 || ov1[71] !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_zero got %h/%h idx=%0d v=%b want zeros",
                  oc1[71], oc0[71], oi1[71], ov1[71]);
      end
      for (int e = 0; e < 90; e++) begin
         w = exp_win(e, 90, 71);
         total++;
         if (ov1[e] !== (w >= 0) || ov0[e] !== (w >= 0)) begin
            bad++;
            $display("FAIL rstmid_valid e%0d got %b/%b want %b", e, ov1[e], ov0[e], w >= 0);
         end
         if (w >= 0) begin
            total++;
            if (oc1[e] !== {model(w, 3, 1), model(w, 2, 1), model(w, 1, 1)}) begin
               bad++; $display("FAIL rstmid_out w%0d got %h", w, oc1[e]);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; pixel = '0; weight = '0; bias = '0;
      test_reset();
      test_ones();
      test_bias_relu();
      test_saturation();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
